// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - b_in over WIDTH cycles, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to compute signed overflow; otherwise ovf_o is tied low.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             b_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             b_out_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, work_q, work_d, diff_q, diff_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              br_q, br_d, b_out_q, b_out_d;
  logic              a0, b0, d_bit, br_next, last;

  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign d_bit   = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign last    = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = b_in_i;
          cnt_d   = '0;
          work_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next;
        work_d = {d_bit, work_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CntW'(1);
        // Result registers update only here, so intermediate shifts never reach the outputs.
        if (last) begin
          diff_d  = {d_bit, work_q[WIDTH-1:1]};
          b_out_d = br_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q, ovf_d;

  // On the final shift br_q is the borrow into the MSB stage and br_next the borrow out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StShift && last) ovf_d = br_q ^ br_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign diff_o      = diff_q;
  assign b_out_o     = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor: WIDTH=8 corner cases plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, bin8 = 1'b0, bo8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0, bin4 = 1'b0, bo4, ovf4;
  logic [3:0] a4 = '0, b4 = '0, d4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv8), .in_ready_o(ir8), .a_i(a8), .b_i(b8),
    .b_in_i(bin8), .out_valid_o(ov8), .out_ready_i(or8), .diff_o(d8), .b_out_o(bo8),
    .ovf_o(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv4), .in_ready_o(ir4), .a_i(a4), .b_i(b4),
    .b_in_i(bin4), .out_valid_o(ov4), .out_ready_i(or4), .diff_o(d4), .b_out_o(bo4),
    .ovf_o(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Accept one operand set on the 8-bit unit, wait for the result and check it.
  task automatic run8(input vec_t v, input string tag, input bit release_out);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, ir8}, 32'd1);
    a8 = v.a; b8 = v.b; bin8 = v.bin; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd8);
    chk({tag, "_diff"}, {24'd0, d8}, {24'd0, v.d});
    chk({tag, "_b_out"}, {31'd0, bo8}, {31'd0, v.bo});
    chk({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, v.ov & OvfEn});
    if (release_out) begin
      or8 = 1'b1;
      @(posedge clk);
      #1 or8 = 1'b0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int prev, acc, k, full, sa, sb, sres;
    vec_t v;
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

    #12;
    chk("rst_in_ready", {31'd0, ir8}, 32'd1);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_diff", {24'd0, d8}, 32'd0);
    chk("rst_b_out", {31'd0, bo8}, 32'd0);
    chk("rst_ovf", {31'd0, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run8(vecs[i], $sformatf("vec%0d", i), 1'b1);

    // Backpressure: result must hold and new operands must be ignored.
    run8(vecs[0], "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'hA0 + 8'(i); b8 = 8'h11; bin8 = 1'b1; iv8 = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, ov8}, 32'd1);
      chk("bp_in_ready", {31'd0, ir8}, 32'd0);
      chk("bp_diff", {24'd0, d8}, 32'h02);
      chk("bp_b_out", {31'd0, bo8}, 32'd0);
      chk("bp_ovf", {31'd0, ovf8}, 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    chk("bp_release_in_ready", {31'd0, ir8}, 32'd1);
    chk("bp_release_out_valid", {31'd0, ov8}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_no_accept", {31'd0, ir8}, 32'd1);
    chk("bp_hold_diff", {24'd0, d8}, 32'h02);

    // Reset after the third shift.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, ov8}, 32'd0);
    chk("midrst_in_ready", {31'd0, ir8}, 32'd1);
    chk("midrst_diff", {24'd0, d8}, 32'd0);
    chk("midrst_b_out", {31'd0, bo8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    run8(v, "post_rst", 1'b1);

    // Exhaustive WIDTH=4 sweep with both handshakes held open.
    iv4 = 1'b1;
    or4 = 1'b1;
    prev = -1;
    for (int idx = 0; idx < 512; idx++) begin
      k = 0;
      @(negedge clk);
      while (!ir4 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) begin
        chk("w4_ready_timeout", 32'd0, 32'd1);
        break;
      end
      a4 = idx[7:4]; b4 = idx[3:0]; bin4 = idx[8];
      acc = cyc + 1;
      if (prev >= 0) chk("w4_interval", acc - prev, 32'd6);
      prev = acc;
      k = 0;
      @(negedge clk);
      while (!ov4 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) begin
        chk("w4_valid_timeout", 32'd0, 32'd1);
        break;
      end
      full = int'(idx[7:4]) - int'(idx[3:0]) - int'(idx[8]);
      sa   = (idx[7:4] >= 8) ? int'(idx[7:4]) - 16 : int'(idx[7:4]);
      sb   = (idx[3:0] >= 8) ? int'(idx[3:0]) - 16 : int'(idx[3:0]);
      sres = sa - sb - int'(idx[8]);
      chk($sformatf("w4_diff_%0d", idx), {28'd0, d4}, full & 15);
      chk($sformatf("w4_b_out_%0d", idx), {31'd0, bo4}, (full < 0) ? 32'd1 : 32'd0);
      chk($sformatf("w4_ovf_%0d", idx), {31'd0, ovf4},
          (OvfEn && (sres < -8 || sres > 7)) ? 32'd1 : 32'd0);
    end
    iv4 = 1'b0;
    or4 = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
